// File: rtl/inst_fetch.sv
// inst_fetch: PC generation, req/ack instruction-memory port, IF/ID register.
// Ports: clk/rst, en/stall, pc_src/branch_taken/rs_data, imem_*, id_*.
module inst_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] rs_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_valid
);

  localparam logic [2:0] SRC_JUMP = 3'd1;
  localparam logic [2:0] SRC_JR   = 3'd2;
  localparam logic [2:0] SRC_BEQ  = 3'd3;

  typedef enum logic [1:0] {
    REQ,
    FULL,
    DISCARD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] fetch_pc;
  logic [31:0] pend_pc;
  logic [31:0] buf_inst;
  logic [31:0] buf_pc;
  logic        adv;
  logic        take;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] jump_tgt;
  logic [31:0] beq_tgt;

  assign adv       = en & ~stall;
  assign imem_addr = fetch_pc;

  assign jump_tgt = {id_pc_plus4[31:28], id_inst[25:0], 2'b00};
  assign beq_tgt  = id_pc_plus4
                  + {{14{id_inst[15]}}, id_inst[15:0], 2'b00};

  // Codes 4-7 fall to the default and behave as NEXT.
  always_comb begin
    take   = 1'b0;
    target = jump_tgt;
    case (pc_src)
      SRC_JUMP: begin
        take   = 1'b1;
        target = jump_tgt;
      end
      SRC_JR: begin
        take   = 1'b1;
        target = rs_data;
      end
      SRC_BEQ: begin
        take   = branch_taken;
        target = beq_tgt;
      end
      default: begin
        take   = 1'b0;
        target = jump_tgt;
      end
    endcase
  end

  assign redirect = adv & id_valid & take;

  always_ff @(posedge clk) begin
    if (rst) state <= REQ;
    else     state <= state_n;
  end

  // A redirect always implies adv, so ack & ~adv never
  // coincides with a redirect in REQ.
  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    unique case (state)
      REQ: begin
        imem_req = 1'b1;
        if (redirect && !imem_ack)
          state_n = DISCARD;
        else if (imem_ack && !adv)
          state_n = FULL;
      end
      FULL: begin
        if (adv) state_n = REQ;
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) state_n = REQ;
      end
      default: state_n = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= PC_RESET;
      pend_pc  <= 32'h0;
      buf_inst <= 32'h0;
      buf_pc   <= 32'h0;
    end else begin
      unique case (state)
        REQ: begin
          if (imem_ack && redirect) begin
            fetch_pc <= target;
          end else if (redirect) begin
            pend_pc <= target;
          end else if (imem_ack) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (!adv) begin
              buf_inst <= imem_data;
              buf_pc   <= fetch_pc;
            end
          end
        end
        FULL: begin
          if (redirect) fetch_pc <= target;
        end
        DISCARD: begin
          // The stale response is consumed, then the
          // deferred target is requested.
          if (imem_ack) fetch_pc <= pend_pc;
        end
        default: fetch_pc <= fetch_pc;
      endcase
    end
  end

  // IF/ID register. A redirect squashes whatever would
  // have entered (no delay slot) and leaves a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_inst     <= 32'h0;
      id_pc       <= 32'h0;
      id_pc_plus4 <= 32'h0;
      id_valid    <= 1'b0;
    end else if (adv) begin
      if (redirect) begin
        id_valid <= 1'b0;
      end else if (state == FULL) begin
        id_inst     <= buf_inst;
        id_pc       <= buf_pc;
        id_pc_plus4 <= buf_pc + 32'd4;
        id_valid    <= 1'b1;
      end else if (state == REQ && imem_ack) begin
        id_inst     <= imem_data;
        id_pc       <= fetch_pc;
        id_pc_plus4 <= fetch_pc + 32'd4;
        id_valid    <= 1'b1;
      end else begin
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a
// wait-state memory model and a small decode/controller model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        stall = 1'b0;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] rs_data = 32'h1234_5678;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;

  int total = 0;
  int bad = 0;
  int wait_n = 0;
  int cnt = 0;
  int prog = 0;
  int beq_take = 0;
  int beq_seen = 0;
  logic adv_seen = 1'b0;

  logic [31:0] sb[$];
  logic [31:0] ea[$];
  bit          er[$];
  bit          ev[$];

  inst_fetch #(.PC_RESET(32'h0)) dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall),
    .pc_src(pc_src), .branch_taken(branch_taken),
    .rs_data(rs_data), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  // Program image: J 0x40 at 0x20, BEQ -4 at 0x40,
  // JR at 0x48; prog 1 adds J 0x80 at 0x0C.
  function automatic logic [31:0] mem_word(
    input logic [31:0] a, input int p);
    if (p == 1 && a == 32'h0C) return 32'h0800_0020;
    case (a)
      32'h20:  return 32'h0800_0010;
      32'h40:  return 32'h1000_FFFF;
      32'h48:  return 32'h0000_0008;
      default: return {4'hF, a[27:0]};
    endcase
  endfunction

  assign imem_ack  = imem_req && (cnt == wait_n);
  assign imem_data = mem_word(imem_addr, prog);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  always_comb begin
    pc_src = 3'd0;
    if (id_inst[31:26] == 6'b000010)
      pc_src = 3'd1;
    else if (id_inst[31:26] == 6'b000100)
      pc_src = 3'd3;
    else if (id_inst[31:26] == 6'b0 &&
             id_inst[5:0] == 6'b001000)
      pc_src = 3'd2;
  end

  assign branch_taken = (beq_seen < beq_take);

  always @(posedge clk) begin
    adv_seen <= en && !stall && !rst;
    if (rst) beq_seen <= 0;
    else if (en && !stall && id_valid &&
             id_inst[31:26] == 6'b000100)
      beq_seen <= beq_seen + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every newly loaded valid IF/ID entry
  // must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [31:0] p;
    if (adv_seen && id_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra got pc=%h exp=none", id_pc);
      end else begin
        p = sb.pop_front();
        chk("sb_pc", id_pc, p);
        chk("sb_inst", id_inst, mem_word(p, prog));
        chk("sb_pc4", id_pc_plus4, p + 32'd4);
      end
    end
  end

  task automatic setup(input int w, input int p,
                       input int bt);
    rst = 1'b1;
    en = 1'b1;
    stall = 1'b0;
    wait_n = w;
    prog = p;
    beq_take = bt;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run(input int scn, input int n);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("s%0d_addr_c%0d", scn, k),
          imem_addr, ea[k]);
      chk($sformatf("s%0d_req_c%0d", scn, k),
          {31'b0, imem_req}, {31'b0, er[k]});
      chk($sformatf("s%0d_valid_c%0d", scn, k),
          {31'b0, id_valid}, {31'b0, ev[k]});
      if (k == 0) begin
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_id_pc4", id_pc_plus4, 32'h0);
      end
      case (scn)
        2: begin
          stall = (k == 2 || k == 3);
          en = (k != 4);
          if (k == 4) chk("stall_hold_pc", id_pc, 32'h4);
        end
        3: if (k == 4) wait_n = 3;
        4: begin
          if (k == 4) wait_n = 3;
          if (k == 6) rst = 1'b1;
          if (k == 7) begin
            rst = 1'b0;
            wait_n = 0;
          end
        end
        default: ;
      endcase
    end
    en = 1'b0;
    stall = 1'b0;
    @(posedge clk);
    chk($sformatf("s%0d_sb_drain", scn),
        sb.size(), 32'h0);
  endtask

  initial begin
    // Zero-wait: sequential, J, BEQ taken then not, JR.
    setup(0, 0, 1);
    sb = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
           32'h18, 32'h1C, 32'h20, 32'h40, 32'h40,
           32'h44, 32'h48, 32'h1234_5678, 32'h1234_567C};
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14,
           32'h18, 32'h1C, 32'h20, 32'h24, 32'h40,
           32'h44, 32'h40, 32'h44, 32'h48, 32'h4C,
           32'h1234_5678, 32'h1234_567C, 32'h1234_5680};
    er = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
           1, 1, 1, 1, 1, 1, 1, 1, 1};
    ev = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1,
           0, 1, 0, 1, 1, 1, 0, 1, 1};
    run(0, 19);

    // Two wait states: one instruction every 3 cycles.
    setup(2, 0, 0);
    sb = '{32'h0, 32'h4, 32'h8};
    ea = '{32'h0, 32'h0, 32'h0, 32'h4, 32'h4, 32'h4,
           32'h8, 32'h8, 32'h8, 32'hC};
    er = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    ev = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    run(1, 10);

    // Hold (stall, then en=0) on the ack of 0x8.
    setup(0, 0, 0);
    sb = '{32'h0, 32'h4, 32'h8, 32'hC};
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC,
           32'hC, 32'h10};
    er = '{1, 1, 1, 0, 0, 0, 1, 1};
    ev = '{0, 1, 1, 1, 1, 1, 1, 1};
    run(2, 8);

    // Redirect to 0x80 while the 0x10 fetch is slow.
    setup(0, 1, 0);
    sb = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h80};
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10,
           32'h10, 32'h10, 32'h80, 32'h80, 32'h80,
           32'h80, 32'h84};
    er = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    ev = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    run(3, 13);

    // Same, with reset asserted inside DISCARD.
    setup(0, 1, 0);
    sb = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0, 32'h4};
    ea = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h10,
           32'h10, 32'h0, 32'h4, 32'h8};
    er = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    ev = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 1};
    run(4, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
